// File: rtl/sram_1rw1r_ctrl.sv
// rtl/sram_1rw1r_ctrl.sv - valid/ready front end for a 1rw1r SRAM macro with per-port read response FIFOs
module sram_resp_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [CW-1:0] cnt_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;
  assign pop     = valid_o & pop_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)    rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset; cnt_q gates visibility.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

module sram_1rw1r_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int RESP_DEPTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_write,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_resp_valid,
  input  logic                  p0_resp_ready,
  output logic [DATA_WIDTH-1:0] p0_resp_rdata,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  output logic                  p1_resp_valid,
  input  logic                  p1_resp_ready,
  output logic [DATA_WIDTH-1:0] p1_resp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [CW:0] OCC_MAX = (CW + 1)'(RESP_DEPTH);

  logic          rd_pend0_q, rd_pend0_d;
  logic          rd_pend1_q, rd_pend1_d;
  logic [CW-1:0] cnt0, cnt1;
  logic [CW:0]   occ0, occ1;
  logic          p0_fire, p1_fire, collide;

  // Reserve a FIFO slot for the read still in the macro pipeline.
  assign occ0 = {1'b0, cnt0} + {{CW{1'b0}}, rd_pend0_q};
  assign occ1 = {1'b0, cnt1} + {{CW{1'b0}}, rd_pend1_q};

  assign p0_req_ready = RST_N & (occ0 < OCC_MAX);
  assign p0_fire      = p0_req_valid & p0_req_ready;
  assign collide      = p0_fire & p0_req_write & p1_req_valid & (p1_req_addr == p0_req_addr);
  assign p1_req_ready = RST_N & (occ1 < OCC_MAX) & ~collide;
  assign p1_fire      = p1_req_valid & p1_req_ready;

  assign sram_csb0  = ~p0_fire;
  assign sram_web0  = ~(p0_fire & p0_req_write);
  assign sram_addr0 = p0_req_addr;
  assign sram_din0  = p0_req_wdata;
  assign sram_csb1  = ~p1_fire;
  assign sram_addr1 = p1_req_addr;

  assign rd_pend0_d = p0_fire & ~p0_req_write;
  assign rd_pend1_d = p1_fire;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_pend0_q <= 1'b0;
      rd_pend1_q <= 1'b0;
    end else begin
      rd_pend0_q <= rd_pend0_d;
      rd_pend1_q <= rd_pend1_d;
    end
  end

  sram_resp_fifo #(.DW(DATA_WIDTH), .DEPTH(RESP_DEPTH), .CW(CW)) u_resp0 (
    .clk         (CLK),
    .rst_n       (RST_N),
    .push_i      (rd_pend0_q),
    .push_data_i (sram_dout0),
    .pop_ready_i (p0_resp_ready),
    .valid_o     (p0_resp_valid),
    .data_o      (p0_resp_rdata),
    .cnt_o       (cnt0)
  );

  sram_resp_fifo #(.DW(DATA_WIDTH), .DEPTH(RESP_DEPTH), .CW(CW)) u_resp1 (
    .clk         (CLK),
    .rst_n       (RST_N),
    .push_i      (rd_pend1_q),
    .push_data_i (sram_dout1),
    .pop_ready_i (p1_resp_ready),
    .valid_o     (p1_resp_valid),
    .data_o      (p1_resp_rdata),
    .cnt_o       (cnt1)
  );
endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// tb/tb_sram_1rw1r_ctrl.sv - directed and random checks of sram_1rw1r_ctrl against a transaction-level model
module tb_sram_1rw1r_ctrl;
  logic        CLK, RST_N;
  logic        p0v, p0w, p1v, r0rdy, r1rdy;
  logic [6:0]  p0a, p1a;
  logic [31:0] p0d;
  logic        p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid;
  logic [31:0] p0_resp_rdata, p1_resp_rdata;
  logic        sram_csb0, sram_web0, sram_csb1;
  logic [6:0]  sram_addr0, sram_addr1;
  logic [31:0] sram_din0, sram_dout0, sram_dout1;

  sram_1rw1r_ctrl dut (
    .CLK(CLK), .RST_N(RST_N),
    .p0_req_valid(p0v), .p0_req_ready(p0_req_ready), .p0_req_write(p0w),
    .p0_req_addr(p0a), .p0_req_wdata(p0d),
    .p0_resp_valid(p0_resp_valid), .p0_resp_ready(r0rdy), .p0_resp_rdata(p0_resp_rdata),
    .p1_req_valid(p1v), .p1_req_ready(p1_req_ready), .p1_req_addr(p1a),
    .p1_resp_valid(p1_resp_valid), .p1_resp_ready(r1rdy), .p1_resp_rdata(p1_resp_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Macro behaviour: registered inputs, read data valid after the capturing edge.
  logic [31:0] mem [128];
  always @(posedge CLK) begin
    if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= mem[sram_addr0];
    end
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  typedef struct {
    logic [31:0] d;
    int          c;
  } ent_t;

  ent_t        q0[$];
  ent_t        q1[$];
  logic [31:0] shadow [128];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          n_resp0 = 0;
  int          n_resp1 = 0;
  bit          obs_f0, obs_f1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit   rst_ok, e_r0, e_r1, e_v0, e_v1, f0, f1, coll;
    ent_t e;
    @(negedge CLK);
    rst_ok = (RST_N === 1'b1);
    e_r0   = rst_ok && (q0.size() < 3);
    f0     = p0v && e_r0;
    coll   = f0 && p0w && p1v && (p1a == p0a);
    e_r1   = rst_ok && (q1.size() < 3) && !coll;
    f1     = p1v && e_r1;
    e_v0   = rst_ok && (q0.size() > 0) && (q0[0].c <= cyc - 2);
    e_v1   = rst_ok && (q1.size() > 0) && (q1[0].c <= cyc - 2);
    chk("p0_req_ready", {31'b0, p0_req_ready}, {31'b0, e_r0});
    chk("p1_req_ready", {31'b0, p1_req_ready}, {31'b0, e_r1});
    chk("p0_resp_valid", {31'b0, p0_resp_valid}, {31'b0, e_v0});
    chk("p1_resp_valid", {31'b0, p1_resp_valid}, {31'b0, e_v1});
    chk("sram_csb0", {31'b0, sram_csb0}, {31'b0, !f0});
    chk("sram_csb1", {31'b0, sram_csb1}, {31'b0, !f1});
    chk("sram_web0", {31'b0, sram_web0}, {31'b0, !(f0 && p0w)});
    if (e_v0) chk("p0_resp_rdata", p0_resp_rdata, q0[0].d);
    if (e_v1) chk("p1_resp_rdata", p1_resp_rdata, q1[0].d);
    if (f0) chk("sram_addr0", {25'b0, sram_addr0}, {25'b0, p0a});
    if (f1) chk("sram_addr1", {25'b0, sram_addr1}, {25'b0, p1a});
    if (f0 && p0w) chk("sram_din0", sram_din0, p0d);
    obs_f0 = p0v && (p0_req_ready === 1'b1);
    obs_f1 = p1v && (p1_req_ready === 1'b1);
    if (p0_resp_valid === 1'b1 && r0rdy) n_resp0++;
    if (p1_resp_valid === 1'b1 && r1rdy) n_resp1++;
    @(posedge CLK);
    if (e_v0 && r0rdy) void'(q0.pop_front());
    if (e_v1 && r1rdy) void'(q1.pop_front());
    if (f0 && !p0w) begin e.d = shadow[p0a]; e.c = cyc; q0.push_back(e); end
    if (f1)         begin e.d = shadow[p1a]; e.c = cyc; q1.push_back(e); end
    if (f0 && p0w) shadow[p0a] = p0d;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    p0v = 0; p1v = 0; r0rdy = 1; r1rdy = 1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int k, fires, guard;
    logic [6:0] bp_addr [5];
    RST_N = 0; p0v = 0; p0w = 0; p0a = 0; p0d = 0; p1v = 0; p1a = 0; r0rdy = 1; r1rdy = 1;
    step(); step();
    RST_N = 1;

    // Preload 0..15 through port 0 (addr*3, addr 9 = 0xFFFF).
    for (int a = 0; a < 16; a++) begin
      p0v = 1; p0w = 1; p0a = 7'(a); p0d = (a == 9) ? 32'hFFFF : 32'(a * 3);
      step();
      chk("preload_fire", {31'b0, obs_f0}, 32'd1);
    end
    idle(1);

    // Back-to-back port-1 reads 0..7.
    fires = 0; n_resp1 = 0;
    for (int a = 0; a < 8; a++) begin
      p1v = 1; p1a = 7'(a); r1rdy = 1;
      step();
      if (obs_f1) fires++;
    end
    idle(4);
    chk("b2b_fires", fires, 8);
    chk("b2b_resp_count", n_resp1, 8);

    // Write 5 then read 5 on port 0.
    n_resp0 = 0;
    p0v = 1; p0w = 1; p0a = 5; p0d = 32'hDEADBEEF; step();
    p0w = 0; step();
    idle(5);
    chk("wr_rd_resp_count", n_resp0, 1);

    // Backpressure: five reads with resp_ready low.
    for (int i = 0; i < 5; i++) bp_addr[i] = 7'(i + 1);
    k = 0; fires = 0; r0rdy = 0; p0w = 0;
    for (int i = 0; i < 5; i++) begin
      p0v = 1; p0a = bp_addr[k];
      step();
      if (obs_f0) begin k++; fires++; end
    end
    chk("bp_accepted", fires, 3);
    r0rdy = 1; guard = 0;
    while (k < 5 && guard < 20) begin
      p0v = 1; p0a = bp_addr[k];
      step();
      if (obs_f0) k++;
      guard++;
    end
    chk("bp_all_accepted", k, 5);
    idle(5);

    // Collision: same address stalls port 1, different address fires together.
    p0v = 1; p0w = 1; p0a = 9; p0d = 32'h1234; p1v = 1; p1a = 9;
    step();
    chk("coll_stall", {31'b0, obs_f1}, 32'd0);
    p0v = 0;
    step();
    chk("coll_retry", {31'b0, obs_f1}, 32'd1);
    p0v = 1; p0w = 1; p0a = 11; p0d = 32'h5555; p1v = 1; p1a = 10;
    step();
    chk("nocoll_p0", {31'b0, obs_f0}, 32'd1);
    chk("nocoll_p1", {31'b0, obs_f1}, 32'd1);
    idle(5);

    // Reset one cycle after a port-1 read fires.
    p1v = 1; p1a = 3; step();
    chk("rst_read_fire", {31'b0, obs_f1}, 32'd1);
    p1v = 0; RST_N = 0;
    q0.delete(); q1.delete();
    step(); step(); step();
    RST_N = 1; n_resp1 = 0;
    idle(5);
    chk("rst_no_resp", n_resp1, 0);

    // Random traffic over the preloaded region.
    for (int i = 0; i < 400; i++) begin
      p0v = 1'($urandom_range(0, 1)); p0w = 1'($urandom_range(0, 1));
      p0a = 7'($urandom_range(0, 15)); p0d = $urandom;
      p1v = 1'($urandom_range(0, 1)); p1a = 7'($urandom_range(0, 15));
      r0rdy = ($urandom_range(0, 3) != 0); r1rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
